// File: rtl/stall_req_gen_pkg.sv
// -----------------------------------------------------------------------------
// stall_req_gen_pkg
// Shared definitions for the ID/EX stall request generator:
//   - REG_ADDR_W : architectural register index width
//   - state_e    : FSM encodings (IDLE / LOAD / MULTI)
//   - cause_e    : stall cause codes reported on cause_o
// -----------------------------------------------------------------------------
package stall_req_gen_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MULTI = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_LOAD  = 2'b01,
    CAUSE_MULTI = 2'b10
  } cause_e;

endpackage

// File: rtl/stall_req_gen_hazard_cmp.sv
// -----------------------------------------------------------------------------
// stall_req_gen_hazard_cmp  (the hazard_cmp comparator)
// Purely combinational load-use detector. Kept separate so that forwarding
// logic can reuse the same register-match comparison.
// Ports:
//   ex_mem_read_i  : EX instruction is a load
//   ex_rd_addr_i   : EX destination register
//   id_rs1_read_i  : ID instruction reads rs1
//   id_rs1_addr_i  : rs1 index
//   id_rs2_read_i  : ID instruction reads rs2
//   id_rs2_addr_i  : rs2 index
//   load_hit_o     : ID needs the value the EX load has not produced yet
// -----------------------------------------------------------------------------
module stall_req_gen_hazard_cmp
  import stall_req_gen_pkg::*;
(
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  id_rs1_read_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs2_read_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  output logic                  load_hit_o
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign rd_nonzero = (ex_rd_addr_i != '0);
  assign rs1_match  = id_rs1_read_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_match  = id_rs2_read_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign load_hit_o = ex_mem_read_i && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/stall_req_gen.sv
// -----------------------------------------------------------------------------
// stall_req_gen
// Requesting end of the ID/EX stall interface. Detects load-use hazards and
// multi-cycle EX operations, holds stallreq for a counted number of cycles and
// then guarantees exactly one release cycle, so the hazard that stays frozen
// in EX during the stall cannot re-trigger forever.
//
// Parameters:
//   LOAD_STALL_CYCLES : stall cycles per load-use hazard (>=1)
//   MULTI_CYCLES      : stall cycles per multi-cycle op unless done early (>=1)
//   CNT_W             : counter width, holds max(LOAD_STALL_CYCLES,MULTI_CYCLES)-1
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   flush_i               : pipeline flush, aborts any stall
//   ex_mem_read_i         : EX instruction is a load
//   ex_rd_addr_i          : EX destination register
//   id_rs1_read_i/addr_i  : ID rs1 usage
//   id_rs2_read_i/addr_i  : ID rs2 usage
//   ex_multi_start_i      : EX instruction is a multi-cycle op
//   ex_multi_done_i       : multi-cycle result ready (early termination)
//   stallreq_id_ex_o      : stall request
//   busy_o                : FSM not IDLE
//   cause_o               : 00 none, 01 load-use, 10 multi-cycle
//   perf_stall_cycles_o   : stalled-cycle counter
//
// Configuration macro STALL_PERF_EN:
//   defined   -> perf_stall_cycles_o counts cycles with stallreq high (wraps,
//                cleared only by rst)
//   undefined -> no counter, perf_stall_cycles_o tied to 0
// -----------------------------------------------------------------------------
module stall_req_gen
  import stall_req_gen_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MULTI_CYCLES      = 32,
  parameter int CNT_W             = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  id_rs1_read_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs2_read_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  ex_multi_start_i,
  input  logic                  ex_multi_done_i,
  output logic                  stallreq_id_ex_o,
  output logic                  busy_o,
  output logic [1:0]            cause_o,
  output logic [31:0]           perf_stall_cycles_o
);

  // The IDLE trigger cycle is already one stall cycle, so the counter is
  // loaded with N-1 remaining cycles.
  localparam logic [CNT_W-1:0] LOAD_CNT_INIT  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULTI_CNT_INIT = CNT_W'(MULTI_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_hit;
  logic             stallreq_c;
  cause_e           cause_c;
  logic             release_c;

  stall_req_gen_hazard_cmp u_hazard_cmp (
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .id_rs1_read_i (id_rs1_read_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_read_i (id_rs2_read_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .load_hit_o    (load_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalling state releases when its count is exhausted, or (MULTI only)
  // when the unit reports its result early.
  assign release_c = (cnt_q == '0) ||
                     ((state_q == ST_MULTI) && ex_multi_done_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stallreq_c = 1'b0;
    cause_c    = CAUSE_NONE;

    if (flush_i) begin
      // Flush kills the hazarding instruction; nothing left to wait for.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_hit) begin
            stallreq_c = 1'b1;
            cause_c    = CAUSE_LOAD;
            state_d    = ST_LOAD;
            cnt_d      = LOAD_CNT_INIT;
          end else if (ex_multi_start_i) begin
            stallreq_c = 1'b1;
            cause_c    = CAUSE_MULTI;
            state_d    = ST_MULTI;
            cnt_d      = MULTI_CNT_INIT;
          end
        end

        ST_LOAD, ST_MULTI: begin
          if (release_c) begin
            // Release cycle: the frozen hazard is still visible in EX, so no
            // trigger is evaluated here.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            stallreq_c = 1'b1;
            cause_c    = (state_q == ST_LOAD) ? CAUSE_LOAD : CAUSE_MULTI;
            cnt_d      = cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are forced low for as long as reset is asserted.
  assign stallreq_id_ex_o = !rst && stallreq_c;
  assign cause_o          = rst ? 2'b00 : cause_c;
  assign busy_o           = !rst && (state_q != ST_IDLE);

`ifdef STALL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stallreq_id_ex_o) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_q;
`else
  assign perf_stall_cycles_o = 32'd0;
`endif

endmodule
